magia_soc_evt_arbiter: RTL and testbench

MAGIA_SOC_EVT_ARBITER -- requirements
Module: magia_soc_evt_arbiter

---
 rtl/magia_soc_evt_arbiter.sv | 163 ++++++++++++++++
 tb/tb_magia_soc_evt_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/magia_soc_evt_arbiter.sv
// -----------------------------------------------------------------------------
// magia_soc_evt_arbiter
//
// Collects one-cycle event pulses from NB_SRC sources and forwards them, one
// at a time, to the event unit SoC event port as event IDs. Each source keeps
// a saturating pending counter. Sources with pending events are served
// round-robin into a single registered output slot with a valid/ready
// handshake.
//
// Parameters:
//   NB_SRC      - number of event sources (1..32)
//   EVNT_WIDTH  - width of the event ID on evt_data_o
//   CNT_W       - width of each per-source pending counter
//   EVT_ID_BASE - event ID assigned to source 0
//
// Ports:
//   clk_i       - clock, all state on the rising edge
//   rst_ni      - asynchronous active-low reset
//   evt_i       - one-cycle event pulses, one bit per source
//   evt_en_i    - per-source enable; disabled pulses are dropped
//   ovf_clr_i   - per-source clear of the sticky overflow flag
//   evt_valid_o - output slot holds an event
//   evt_data_o  - event ID in the output slot
//   evt_ready_i - event unit accepts the slot contents
//   ovf_o       - sticky per-source overflow flags
//   busy_o      - any event pending or slot occupied
// -----------------------------------------------------------------------------
module magia_soc_evt_arbiter #(
  parameter int NB_SRC      = 8,
  parameter int EVNT_WIDTH  = 8,
  parameter int CNT_W       = 4,
  parameter int EVT_ID_BASE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_SRC-1:0]     evt_i,
  input  logic [NB_SRC-1:0]     evt_en_i,
  input  logic [NB_SRC-1:0]     ovf_clr_i,
  output logic                  evt_valid_o,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  input  logic                  evt_ready_i,
  output logic [NB_SRC-1:0]     ovf_o,
  output logic                  busy_o
);

  localparam int PTR_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reject configurations whose highest event ID does not fit the ID field.
  if ((NB_SRC < 1) || (NB_SRC > 32)) begin : g_bad_nb_src
    $error("magia_soc_evt_arbiter: NB_SRC must be in 1..32");
  end
  if (((EVT_ID_BASE + NB_SRC - 1) >> EVNT_WIDTH) != 0) begin : g_bad_id_range
    $error("magia_soc_evt_arbiter: EVT_ID_BASE+NB_SRC-1 does not fit in EVNT_WIDTH");
  end

  logic [CNT_W-1:0]  cnt [NB_SRC];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  sel;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [NB_SRC-1:0] pend;
  logic [NB_SRC-1:0] inc;
  logic [NB_SRC-1:0] dec;
  logic [NB_SRC-1:0] ovf_set;
  logic              found;
  logic              loadable;
  logic              grant;

  assign inc      = evt_i & evt_en_i;
  assign loadable = ~evt_valid_o | evt_ready_i;
  assign grant    = loadable & found;

  always_comb begin
    for (int i = 0; i < NB_SRC; i++) begin
      pend[i] = (cnt[i] != '0);
    end
  end

  // First pending source at or above ptr, wrapping past the top source.
  // Only registered counts are looked at, so a new pulse is grantable one
  // edge after it was counted.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int off = 0; off < NB_SRC; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NB_SRC) begin
        idx = idx - NB_SRC;
      end
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_nxt = sel + 1'b1;
    if (int'(sel) == NB_SRC - 1) begin
      ptr_nxt = '0;
    end
  end

  always_comb begin
    dec = '0;
    if (grant) begin
      dec[sel] = 1'b1;
    end
  end

  // A saturated counter drops an incoming event unless the same source is
  // granted this cycle, in which case the increment and decrement cancel.
  always_comb begin
    for (int i = 0; i < NB_SRC; i++) begin
      ovf_set[i] = inc[i] & ~dec[i] & (cnt[i] == CNT_MAX);
    end
  end

  always_comb begin
    busy_o = evt_valid_o;
    for (int i = 0; i < NB_SRC; i++) begin
      busy_o = busy_o | pend[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_SRC; i++) begin
        cnt[i] <= '0;
      end
      ptr         <= '0;
      evt_valid_o <= 1'b0;
      evt_data_o  <= '0;
      ovf_o       <= '0;
    end else begin
      for (int i = 0; i < NB_SRC; i++) begin
        if (inc[i] && !dec[i]) begin
          if (cnt[i] != CNT_MAX) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end

      // A set in the same cycle as a clear keeps the flag.
      ovf_o <= ovf_set | (ovf_o & ~ovf_clr_i);

      if (loadable) begin
        if (found) begin
          evt_valid_o <= 1'b1;
          evt_data_o  <= EVNT_WIDTH'(EVT_ID_BASE + int'(sel));
          ptr         <= ptr_nxt;
        end else begin
          evt_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_magia_soc_evt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_magia_soc_evt_arbiter
//
// Self-checking bench for magia_soc_evt_arbiter (8 sources, 4-bit counters,
// event IDs starting at 16). A table of per-cycle vectors covers latency,
// round-robin order, pointer wrap and enable masking; hand-written sequences
// cover backpressure, saturation, overflow set/clear and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_magia_soc_evt_arbiter;

  localparam int NB_SRC     = 8;
  localparam int EVNT_WIDTH = 8;
  localparam int CNT_W      = 4;
  localparam int BASE       = 16;
  localparam int NUM_VECS   = 24;

  logic                  clk;
  logic                  rst_n;
  logic [NB_SRC-1:0]     evt;
  logic [NB_SRC-1:0]     evt_en;
  logic [NB_SRC-1:0]     ovf_clr;
  logic                  valid;
  logic [EVNT_WIDTH-1:0] data;
  logic                  ready;
  logic [NB_SRC-1:0]     ovf;
  logic                  busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0] evt;
    logic [7:0] en;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_src;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [NUM_VECS];

  magia_soc_evt_arbiter #(
    .NB_SRC      (NB_SRC),
    .EVNT_WIDTH  (EVNT_WIDTH),
    .CNT_W       (CNT_W),
    .EVT_ID_BASE (BASE)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .evt_i       (evt),
    .evt_en_i    (evt_en),
    .ovf_clr_i   (ovf_clr),
    .evt_valid_o (valid),
    .evt_data_o  (data),
    .evt_ready_i (ready),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] id(input int k);
    return 8'(BASE + k);
  endfunction

  // Drive inputs for one edge, then step to 1 time unit after that edge.
  task automatic applyStimulus(input logic [7:0] e, input logic [7:0] en,
                               input logic [7:0] clr, input logic rdy);
    evt     = e;
    evt_en  = en;
    ovf_clr = clr;
    ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  // Data is only compared when a valid event is expected or when asked to.
  task automatic checkOutput(input string name, input logic exp_valid,
                             input logic [7:0] exp_data, input logic [7:0] exp_ovf,
                             input logic exp_busy, input logic check_data);
    logic data_ok;
    data_ok = (exp_valid || check_data) ? (data === exp_data) : 1'b1;
    tests_run++;
    if ((valid !== exp_valid) || !data_ok || (ovf !== exp_ovf) || (busy !== exp_busy)) begin
      tests_failed++;
      $display("[TB] FAIL %s: got valid=%0b data=%0d ovf=%02h busy=%0b, want valid=%0b data=%0d ovf=%02h busy=%0b",
               name, valid, data, ovf, busy, exp_valid, exp_data, exp_ovf, exp_busy);
    end
  endtask

  initial begin
    // {evt, en, ready, exp_valid, exp_src, exp_busy}; one row per clock edge
    vecs[0]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[1]  = '{8'h01, 8'hFF, 1'b1, 1'b1, 8'd0, 1'b1};
    vecs[2]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd1, 1'b1};
    vecs[3]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd2, 1'b1};
    vecs[4]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd3, 1'b1};
    vecs[5]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd4, 1'b1};
    vecs[6]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd5, 1'b1};
    vecs[7]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd6, 1'b1};
    vecs[8]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd7, 1'b1};
    vecs[9]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd0, 1'b1};
    vecs[10] = '{8'h00, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[11] = '{8'h01, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[12] = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd0, 1'b1};
    vecs[13] = '{8'h00, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[14] = '{8'h10, 8'hEF, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[15] = '{8'h10, 8'hEF, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[16] = '{8'h00, 8'hEF, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[17] = '{8'h20, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[18] = '{8'h00, 8'hDF, 1'b1, 1'b1, 8'd5, 1'b1};
    vecs[19] = '{8'h00, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[20] = '{8'h42, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[21] = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd6, 1'b1};
    vecs[22] = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'd1, 1'b1};
    vecs[23] = '{8'h00, 8'hFF, 1'b1, 1'b0, 8'd0, 1'b0};

    rst_n   = 1'b0;
    evt     = '0;
    evt_en  = '0;
    ovf_clr = '0;
    ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Round-robin with same-cycle grant+increment on source 0, latency,
    // enable masking, delivery after disable, pointer wrap.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].evt, vecs[i].en, 8'h00, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, id(int'(vecs[i].exp_src)),
                  8'h00, vecs[i].exp_busy, 1'b0);
    end

    // Backpressure: source 3 held in the slot for five ready=0 cycles.
    applyStimulus(8'h08, 8'hFF, 8'h00, 1'b0);
    checkOutput("bp_pending", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h01, 8'hFF, 8'h00, 1'b0);
    checkOutput("bp_load", 1'b1, id(3), 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0);
      checkOutput($sformatf("bp_hold%0d", i), 1'b1, id(3), 8'h00, 1'b1, 1'b0);
    end
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("bp_accept", 1'b1, id(0), 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("bp_idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Saturation on source 2: pulse 2 loads the slot, pulse 17 overflows.
    for (int p = 1; p <= 17; p++) begin
      applyStimulus(8'h04, 8'hFF, 8'h00, 1'b0);
      checkOutput($sformatf("sat_pulse%0d", p), (p >= 2), id(2),
                  (p == 17) ? 8'h04 : 8'h00, 1'b1, 1'b0);
    end
    for (int d = 0; d < 15; d++) begin
      applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
      checkOutput($sformatf("sat_drain%0d", d), 1'b1, id(2), 8'h04, 1'b1, 1'b0);
    end
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("sat_empty", 1'b0, 8'h00, 8'h04, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'h04, 1'b1);
    checkOutput("sat_clear", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Overflow set and clear on source 1 in the same cycle.
    for (int p = 1; p <= 16; p++) begin
      applyStimulus(8'h02, 8'hFF, 8'h00, 1'b0);
      checkOutput($sformatf("s1_pulse%0d", p), (p >= 2), id(1), 8'h00, 1'b1, 1'b0);
    end
    applyStimulus(8'h02, 8'hFF, 8'h02, 1'b0);
    checkOutput("ovf_set_and_clr", 1'b1, id(1), 8'h02, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'h02, 1'b0);
    checkOutput("ovf_clr_only", 1'b1, id(1), 8'h00, 1'b1, 1'b0);
    for (int d = 0; d < 15; d++) begin
      applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
      checkOutput($sformatf("s1_drain%0d", d), 1'b1, id(1), 8'h00, 1'b1, 1'b0);
    end
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("s1_empty", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of a stalled handshake with counts pending.
    applyStimulus(8'h30, 8'hFF, 8'h00, 1'b0);
    checkOutput("rst_pending", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h04, 8'hFF, 8'h00, 1'b0);
    checkOutput("rst_slot_loaded", 1'b1, id(4), 8'h00, 1'b1, 1'b0);
    evt = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("rst_flushed", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'h82, 8'hFF, 8'h00, 1'b1);
    checkOutput("rst_new_pending", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("rst_first_grant", 1'b1, id(1), 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("rst_second_grant", 1'b1, id(7), 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1);
    checkOutput("rst_idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
